// File: rtl/pixel_write_arbiter_if.sv
// Pixel-write bundle between the two drawing engines, the arbiter and the VGA plot port.
// The master side is the drawing engines plus the adapter hold; the slave side is the arbiter.
interface pixel_write_arbiter_if;
  logic       s0_valid;
  logic       s0_ready;
  logic [7:0] s0_x;
  logic [6:0] s0_y;
  logic [2:0] s0_colour;
  logic       s1_valid;
  logic       s1_ready;
  logic [7:0] s1_x;
  logic [6:0] s1_y;
  logic [2:0] s1_colour;
  logic       hold;
  logic       writeEn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;
  logic [7:0] drop_count;

  modport master (
    output s0_valid, s0_x, s0_y, s0_colour,
    output s1_valid, s1_x, s1_y, s1_colour,
    output hold,
    input  s0_ready, s1_ready,
    input  writeEn, x, y, colour, busy, drop_count
  );

  modport slave (
    input  s0_valid, s0_x, s0_y, s0_colour,
    input  s1_valid, s1_x, s1_y, s1_colour,
    input  hold,
    output s0_ready, s1_ready,
    output writeEn, x, y, colour, busy, drop_count
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin merge of the board drawer (source 0) and cursor drawer (source 1) into the
// VGA plot port, with off-screen clipping, a small FIFO and one-cycle writeEn pulses.
module pixel_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input logic                clock,
  input logic                reset,
  pixel_write_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            prio;
  logic            write_en;
  pixel_t          out_px;
  logic [7:0]      drops;

  logic            space;
  logic            grant0;
  logic            grant1;
  logic            xfer;
  logic            in_range;
  logic            push;
  logic            pop;
  pixel_t          incoming;

  // Space looks only at the registered count, so a pop in the same cycle never frees a slot early.
  always_comb begin
    space    = count < CW'(DEPTH);
    grant0   = ~reset & space & bus.s0_valid & (~prio | ~bus.s1_valid);
    grant1   = ~reset & space & bus.s1_valid & ( prio | ~bus.s0_valid);
    xfer     = grant0 | grant1;
    incoming = grant1 ? {bus.s1_x, bus.s1_y, bus.s1_colour}
                      : {bus.s0_x, bus.s0_y, bus.s0_colour};
    in_range = ({1'b0, incoming.x} < X_LIM) && ({1'b0, incoming.y} < Y_LIM);
    push     = xfer & in_range;
    pop      = ~bus.hold & (count != '0);
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= incoming;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      prio     <= 1'b0;
      write_en <= 1'b0;
      out_px   <= '0;
      drops    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (pop) begin
        write_en <= 1'b1;
        out_px   <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end else begin
        write_en <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Priority passes to the other source after any handshake, clipped or not.
      if (xfer) begin
        prio <= grant0;
      end

      if (xfer && !in_range && drops != 8'hFF) begin
        drops <= drops + 8'd1;
      end
    end
  end

  assign bus.s0_ready   = grant0;
  assign bus.s1_ready   = grant1;
  assign bus.writeEn    = write_en;
  assign bus.x          = out_px.x;
  assign bus.y          = out_px.y;
  assign bus.colour     = out_px.colour;
  assign bus.busy       = (count != '0) | write_en;
  assign bus.drop_count = drops;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed tests for pixel_write_arbiter: reset, latency, alternation, streaming,
// hold back-pressure, clipping, mid-stream reset and drop counter saturation.
module tb_pixel_write_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   fails;

  pixel_write_arbiter_if bus ();

  pixel_write_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change just after each rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] x0, input logic [6:0] y0,
                               input logic [2:0] c0, input logic v1, input logic [7:0] x1,
                               input logic [6:0] y1, input logic [2:0] c1, input logic h);
    bus.s0_valid  = v0;
    bus.s0_x      = x0;
    bus.s0_y      = y0;
    bus.s0_colour = c0;
    bus.s1_valid  = v1;
    bus.s1_x      = x1;
    bus.s1_y      = y1;
    bus.s1_colour = c1;
    bus.hold      = h;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1, 8'd1, 7'd1, 3'd1, 1, 8'd2, 7'd2, 3'd2, 0);
    tick();
    @(negedge clock);
    checks++;
    if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ready: got %b%b expected 00", bus.s0_ready, bus.s1_ready);
    end
    checks++;
    if ({bus.writeEn, bus.x, bus.y, bus.colour} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL reset_out: got we=%b x=%0d y=%0d c=%0d expected all 0",
               bus.writeEn, bus.x, bus.y, bus.colour);
    end
    checks++;
    if (bus.drop_count !== 8'd0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_status: got drop=%0d busy=%b expected 0/0",
               bus.drop_count, bus.busy);
    end
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    applyStimulus(1, 8'd3, 7'd5, 3'd7, 0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (bus.s0_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_ready: got %b expected 1", bus.s0_ready);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (bus.writeEn !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_wait: got we=%b busy=%b expected 0/1", bus.writeEn, bus.busy);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.writeEn !== 1'b1 || bus.x !== 8'd3 || bus.y !== 7'd5 || bus.colour !== 3'd7) begin
      fails++;
      $display("[TB] FAIL single_plot: got we=%b x=%0d y=%0d c=%0d expected 1 3 5 7",
               bus.writeEn, bus.x, bus.y, bus.colour);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.writeEn !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_idle: got we=%b busy=%b expected 0/0", bus.writeEn, bus.busy);
    end
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i < 8, 8'd10, 7'd10, 3'd1, i < 8, 8'd20, 7'd20, 3'd4, 0);
      @(negedge clock);
      if (i < 8) begin
        checks++;
        if (bus.s0_ready !== (i % 2 == 0) || bus.s1_ready !== (i % 2 == 1)) begin
          fails++;
          $display("[TB] FAIL alt_grant cycle %0d: got s0=%b s1=%b expected s0=%b s1=%b",
                   i, bus.s0_ready, bus.s1_ready, i % 2 == 0, i % 2 == 1);
        end
      end
      if (i >= 2 && i < 10) begin
        checks++;
        if (bus.writeEn !== 1'b1 || bus.colour !== ((i % 2 == 0) ? 3'd1 : 3'd4)) begin
          fails++;
          $display("[TB] FAIL alt_out cycle %0d: got we=%b c=%0d expected 1 %0d",
                   i, bus.writeEn, bus.colour, (i % 2 == 0) ? 1 : 4);
        end
      end else begin
        checks++;
        if (bus.writeEn !== 1'b0) begin
          fails++;
          $display("[TB] FAIL alt_idle cycle %0d: got we=%b expected 0", i, bus.writeEn);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 0, 0, 0, i < 10, 8'(i), 7'(i), 3'd3, 0);
      @(negedge clock);
      if (i < 10) begin
        checks++;
        if (bus.s1_ready !== 1'b1) begin
          fails++;
          $display("[TB] FAIL b2b_ready cycle %0d: got %b expected 1", i, bus.s1_ready);
        end
      end
      if (i >= 2 && i < 12) begin
        checks++;
        if (bus.writeEn !== 1'b1 || bus.x !== 8'(i - 2) || bus.y !== 7'(i - 2)) begin
          fails++;
          $display("[TB] FAIL b2b_out cycle %0d: got we=%b x=%0d y=%0d expected 1 %0d %0d",
                   i, bus.writeEn, bus.x, bus.y, i - 2, i - 2);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    int sent;
    int got;
    sent = 0;
    got  = 0;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      applyStimulus(sent < 6, 8'(sent), 7'd1, 3'd2, 0, 0, 0, 0, cyc < 6);
      @(negedge clock);
      if (cyc < 6) begin
        checks++;
        if (bus.s0_ready !== (cyc < 4) || bus.writeEn !== 1'b0) begin
          fails++;
          $display("[TB] FAIL hold_fill cycle %0d: got ready=%b we=%b expected %b 0",
                   cyc, bus.s0_ready, bus.writeEn, cyc < 4);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (bus.s0_ready !== 1'b0) begin
          fails++;
          $display("[TB] FAIL hold_full: got ready=%b expected 0", bus.s0_ready);
        end
      end
      if (cyc == 7) begin
        checks++;
        if (bus.writeEn !== 1'b1) begin
          fails++;
          $display("[TB] FAIL hold_resume: got we=%b expected 1", bus.writeEn);
        end
      end
      if (bus.writeEn === 1'b1) begin
        checks++;
        if (bus.x !== 8'(got) || bus.colour !== 3'd2) begin
          fails++;
          $display("[TB] FAIL hold_order: got x=%0d c=%0d expected x=%0d c=2",
                   bus.x, bus.colour, got);
        end
        got++;
      end
      if (bus.s0_ready === 1'b1) sent++;
      tick();
    end
    checks++;
    if (got != 6 || sent != 6) begin
      fails++;
      $display("[TB] FAIL hold_total: got sent=%0d written=%0d expected 6/6", sent, got);
    end
  endtask

  task automatic test_clip();
    logic [7:0] cx [3];
    logic [6:0] cy [3];
    int pulses;
    cx = '{8'd160, 8'd0, 8'd159};
    cy = '{7'd0, 7'd120, 7'd119};
    pulses = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 3) applyStimulus(0, 0, 0, 0, 1, cx[i], cy[i], 3'd5, 0);
      else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      if (i < 3) begin
        checks++;
        if (bus.s1_ready !== 1'b1) begin
          fails++;
          $display("[TB] FAIL clip_ready cycle %0d: got %b expected 1", i, bus.s1_ready);
        end
      end
      if (bus.writeEn === 1'b1) begin
        pulses++;
        checks++;
        if (bus.x !== 8'd159 || bus.y !== 7'd119 || bus.colour !== 3'd5) begin
          fails++;
          $display("[TB] FAIL clip_pixel: got x=%0d y=%0d c=%0d expected 159 119 5",
                   bus.x, bus.y, bus.colour);
        end
      end
      tick();
    end
    checks++;
    if (pulses != 1 || bus.drop_count !== 8'd2) begin
      fails++;
      $display("[TB] FAIL clip_count: got pulses=%0d drop=%0d expected 1/2",
               pulses, bus.drop_count);
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 8'(40 + i), 7'd2, 3'd6, 0, 0, 0, 0, 1);
      @(negedge clock);
      checks++;
      if (bus.s0_ready !== 1'b1) begin
        fails++;
        $display("[TB] FAIL flush_fill %0d: got %b expected 1", i, bus.s0_ready);
      end
      tick();
    end
    reset = 1'b1;
    applyStimulus(1, 8'd50, 7'd2, 3'd6, 1, 8'd51, 7'd2, 3'd6, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0 || bus.writeEn !== 1'b0) begin
        fails++;
        $display("[TB] FAIL flush_during: got s0=%b s1=%b we=%b expected 0 0 0",
                 bus.s0_ready, bus.s1_ready, bus.writeEn);
      end
      tick();
    end
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (bus.writeEn !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL flush_after cycle %0d: got we=%b busy=%b expected 0/0",
                 i, bus.writeEn, bus.busy);
      end
      tick();
    end
    applyStimulus(1, 8'd7, 7'd8, 3'd3, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clock);
    checks++;
    if (bus.writeEn !== 1'b1 || bus.x !== 8'd7 || bus.y !== 7'd8 || bus.colour !== 3'd3) begin
      fails++;
      $display("[TB] FAIL flush_new: got we=%b x=%0d y=%0d c=%0d expected 1 7 8 3",
               bus.writeEn, bus.x, bus.y, bus.colour);
    end
    tick();
  endtask

  task automatic test_saturate();
    logic saw_write;
    saw_write = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 8'd200, 7'd0, 3'd1, 0, 0, 0, 0, 0);
      @(negedge clock);
      if (bus.writeEn === 1'b1) saw_write = 1'b1;
      if (i == 100 || i == 254 || i == 255 || i == 299) begin
        checks++;
        if (bus.drop_count !== ((i < 255) ? 8'(i) : 8'd255)) begin
          fails++;
          $display("[TB] FAIL sat_count at %0d: got %0d expected %0d",
                   i, bus.drop_count, (i < 255) ? i : 255);
        end
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (bus.drop_count !== 8'd255 || saw_write !== 1'b0) begin
      fails++;
      $display("[TB] FAIL sat_final: got drop=%0d wrote=%b expected 255/0",
               bus.drop_count, saw_write);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_hold();
    test_clip();
    test_reset_flush();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
